// File: rtl/if_id_stage.sv
// Instruction fetch and IF/ID pipeline register for the 5-stage MIPS datapath.
// Optional macro IF_ID_DELAY_SLOT_EN keeps the delay-slot instruction on redirect.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [5:0]  if_id_opcode,
  output logic [4:0]  if_id_rs,
  output logic [4:0]  if_id_rt,
  output logic [4:0]  if_id_rd,
  output logic [15:0] if_id_imm16
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    // A stall freezes everything, including a pending redirect.
    if (!stall) begin
      if (redirect) begin
        pc_d = {redirect_target[31:2], 2'b00};
`ifdef IF_ID_DELAY_SLOT_EN
        instr_d = imem_data;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
`else
        instr_d = NOP_INSTR;
        pc4_d   = 32'd0;
        valid_d = 1'b0;
`endif
      end else begin
        pc_d    = pc_plus4;
        instr_d = imem_data;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr      = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pc4_q;
  assign if_id_valid    = valid_q;
  assign if_id_opcode   = instr_q[31:26];
  assign if_id_rs       = instr_q[25:21];
  assign if_id_rt       = instr_q[20:16];
  assign if_id_rd       = instr_q[15:11];
  assign if_id_imm16    = instr_q[15:0];

endmodule
